// File: rtl/mau_pkg.sv
// Shared types for the memory access unit: FSM state encoding, access size codes
// and the alignment rule used to abort an access before it reaches memory.
// Latency: n/a (types and a pure function only). Backpressure: n/a.
package mau_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_ISSUE = 3'd1,
    RD_WAIT  = 3'd2,
    WRITE    = 3'd3,
    DONE     = 3'd4,
    ERR      = 3'd5
  } state_t;

  localparam logic [1:0] SZ_WORD = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_BYTE = 2'd2;

  // Reserved size, odd halfword address or non-word-aligned word address.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_WORD: bad = (off != 2'b00);
      SZ_HALF: bad = off[0];
      SZ_BYTE: bad = 1'b0;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/byte_lane_merge.sv
// Little-endian lane handling: extracts/extends a load lane from a word and
// inserts a store lane into a word. Latency: combinational. Backpressure: none.
// Ports: size/sign_ext/off select the lane; word is the memory word; wdata is the
// right-justified store data; load_data is the extended lane; store_data the merged word.
module byte_lane_merge
  import mau_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  off,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b     = word[{off, 3'b000} +: 8];
    lane_h     = off[1] ? word[31:16] : word[15:0];
    load_data  = word;
    store_data = wdata;
    case (size)
      SZ_BYTE: begin
        load_data  = {{24{sign_ext & lane_b[7]}}, lane_b};
        store_data = word;
        store_data[{off, 3'b000} +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data  = {{16{sign_ext & lane_h[15]}}, lane_h};
        store_data = word;
        if (off[1]) store_data[31:16] = wdata[15:0];
        else        store_data[15:0]  = wdata[15:0];
      end
      default: begin
        load_data  = word;
        store_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store unit: one access at a time, sub-word stores done as read-modify-write.
// Latency req->done: load 3, word store 2, sub-word store 4, misaligned 1 cycle.
// Backpressure: req is only sampled in IDLE; busy is high otherwise and req is ignored.
// Ports: clock/reset (async active-low); req/wr/size/sign_ext/addr/wdata request;
// busy/done/misaligned/rdata status; mem_addr/mem_wr/mem_wdata/mem_rdata memory side.
module mem_access_unit
  import mau_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        misaligned,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  state_t      state, state_nxt;
  logic        op_wr;
  logic [1:0]  op_size;
  logic        op_sx;
  logic [1:0]  op_off;
  logic [31:0] op_wdata;
  logic [31:0] rd_word;
  logic        accept;
  logic        req_bad;
  logic [31:0] lane_word;
  logic [31:0] load_data;
  logic [31:0] store_data;

  assign accept  = (state == IDLE) && req;
  assign req_bad = is_misaligned(size, addr[1:0]);

  // Merge against the live read data while it is valid; extract from the
  // captured copy once the access has moved on to DONE.
  assign lane_word = (state == RD_WAIT) ? mem_rdata : rd_word;

  byte_lane_merge u_lane (
    .size       (op_size),
    .sign_ext   (op_sx),
    .off        (op_off),
    .word       (lane_word),
    .wdata      (op_wdata),
    .load_data  (load_data),
    .store_data (store_data)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      op_wr     <= 1'b0;
      op_size   <= SZ_WORD;
      op_sx     <= 1'b0;
      op_off    <= 2'b00;
      op_wdata  <= '0;
      rd_word   <= '0;
      rdata     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_wr    <= wr;
        op_size  <= size;
        op_sx    <= sign_ext;
        op_off   <= addr[1:0];
        op_wdata <= wdata;
        mem_addr <= {addr[31:2], 2'b00};
        // Word stores skip the read, so the write word is ready immediately.
        if (wr && size == SZ_WORD && !req_bad) mem_wdata <= wdata;
      end
      if (state == RD_WAIT) begin
        rd_word <= mem_rdata;
        if (op_wr) mem_wdata <= store_data;
      end
      if (state == DONE && !op_wr) rdata <= load_data;
    end
  end

  always_comb begin
    state_nxt  = state;
    busy       = (state != IDLE);
    done       = 1'b0;
    misaligned = 1'b0;
    mem_wr     = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (req_bad)                    state_nxt = ERR;
          else if (wr && size == SZ_WORD) state_nxt = WRITE;
          else                            state_nxt = RD_ISSUE;
        end
      end
      RD_ISSUE: state_nxt = RD_WAIT;
      RD_WAIT:  state_nxt = op_wr ? WRITE : DONE;
      WRITE: begin
        mem_wr    = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      ERR: begin
        done       = 1'b1;
        misaligned = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed scenarios plus random accesses checked
// against a word-array reference model with arithmetic lane handling.
module tb_mem_access_unit;
  import mau_pkg::*;

  logic        clock;
  logic        reset;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        misaligned;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  mem_access_unit dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .wr         (wr),
    .size       (size),
    .sign_ext   (sign_ext),
    .addr       (addr),
    .wdata      (wdata),
    .busy       (busy),
    .done       (done),
    .misaligned (misaligned),
    .rdata      (rdata),
    .mem_addr   (mem_addr),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory with one-cycle read latency, plus a preload port for the stimulus.
  logic [31:0] mem [0:63];
  logic        pl_en;
  logic [5:0]  pl_idx;
  logic [31:0] pl_dat;
  int          wr_count = 0;
  int          done_count = 0;
  logic [31:0] last_wa = '0;
  logic [31:0] last_wd = '0;

  always @(posedge clock) begin
    if (pl_en) mem[pl_idx] <= pl_dat;
    else if (mem_wr) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      wr_count <= wr_count + 1;
      last_wa  <= mem_addr;
      last_wd  <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[7:2]];
    if (done) done_count <= done_count + 1;
  end

  // Reference model state.
  logic [31:0] ref_mem [0:63];
  logic [31:0] exp_rdata;
  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] sz,
                                           input logic sx, input logic [1:0] off);
    int bits;
    logic [31:0] m, v;
    if (sz == SZ_WORD) return w;
    bits = (sz == SZ_BYTE) ? 8 : 16;
    m = (32'h1 << bits) - 32'h1;
    v = (w >> (8 * off)) & m;
    if (sx && ((v >> (bits - 1)) & 32'h1) == 32'h1) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] ref_insert(input logic [31:0] w, input logic [31:0] d,
                                             input logic [1:0] sz, input logic [1:0] off);
    int bits;
    logic [31:0] m;
    if (sz == SZ_WORD) return d;
    bits = (sz == SZ_BYTE) ? 8 : 16;
    m = ((32'h1 << bits) - 32'h1) << (8 * off);
    return (w & ~m) | ((d << (8 * off)) & m);
  endfunction

  task automatic poke(input int idx, input logic [31:0] d);
    pl_idx = 6'(idx);
    pl_dat = d;
    pl_en  = 1'b1;
    @(posedge clock); #1;
    pl_en  = 1'b0;
    ref_mem[idx] = d;
  endtask

  task automatic do_access(input logic w, input logic [1:0] sz, input logic sx,
                           input logic [31:0] a, input logic [31:0] wd, input logic hold);
    logic        mis;
    int          lat, idx, wc0, cyc;
    logic [31:0] old_w, new_w;
    idx   = int'(a[7:2]);
    old_w = ref_mem[idx];
    mis   = (sz == 2'd3) || (sz == SZ_HALF && a[0]) || (sz == SZ_WORD && a[1:0] != 2'b00);
    if (mis)                lat = 1;
    else if (!w)            lat = 3;
    else if (sz == SZ_WORD) lat = 2;
    else                    lat = 4;
    new_w = ref_insert(old_w, wd, sz, a[1:0]);
    wc0   = wr_count;

    wr = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clock); #1;
    cyc = 1;
    if (!hold) begin
      req = 1'b0;
      wr = ~w; size = 2'(~sz); addr = ~a; wdata = ~wd;  // must be ignored
    end
    check("busy_after_req", 32'(busy), 32'd1);
    while (!done && cyc < 8) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("done_seen", 32'(done), 32'd1);
    check("latency", cyc, lat);
    check("misaligned", 32'(misaligned), 32'(mis));

    if (!mis && !w) exp_rdata = ref_load(old_w, sz, sx, a[1:0]);
    if (!mis && w)  ref_mem[idx] = new_w;

    @(posedge clock); #1;
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    if (hold) begin
      req = 1'b0;
      @(posedge clock); #1;
      check("no_reaccept", 32'(busy), 32'd0);
    end
    check("rdata", rdata, exp_rdata);
    check("write_count", wr_count - wc0, (!mis && w) ? 1 : 0);
    if (!mis && w) begin
      check("wr_addr", last_wa, {a[31:2], 2'b00});
      check("wr_data", last_wd, new_w);
    end
  endtask

  initial begin
    int wc0, dc0;
    logic [1:0] rsz;
    reset = 1'b0; req = 1'b0; wr = 1'b0; size = 2'd0; sign_ext = 1'b0;
    addr = '0; wdata = '0; pl_en = 1'b0; pl_idx = '0; pl_dat = '0;
    exp_rdata = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_mis", 32'(misaligned), 32'd0);
    check("rst_mem_wr", 32'(mem_wr), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;

    for (int i = 0; i < 64; i++) poke(i, $urandom);

    // Word load.
    poke(16, 32'h11223344);
    do_access(1'b0, SZ_WORD, 1'b0, 32'h40, 32'h0, 1'b0);
    // Signed and unsigned byte load of a negative lane.
    poke(16, 32'h80FF7F01);
    do_access(1'b0, SZ_BYTE, 1'b1, 32'h43, 32'h0, 1'b0);
    check("lb_value", rdata, 32'hFFFFFF80);
    do_access(1'b0, SZ_BYTE, 1'b0, 32'h43, 32'h0, 1'b0);
    check("lbu_value", rdata, 32'h00000080);
    // Halfword store into the upper lane.
    poke(16, 32'hAABBCCDD);
    do_access(1'b1, SZ_HALF, 1'b0, 32'h42, 32'h00001234, 1'b0);
    check("sh_word", last_wd, 32'h1234CCDD);
    // Misaligned word load leaves rdata alone.
    do_access(1'b0, SZ_WORD, 1'b0, 32'h41, 32'h0, 1'b0);

    // Reset while a byte store sits in RD_WAIT.
    poke(16, 32'hA1B2C3D4);
    wc0 = wr_count; dc0 = done_count;
    wr = 1'b1; size = SZ_BYTE; sign_ext = 1'b0; addr = 32'h41; wdata = 32'h5A; req = 1'b1;
    @(posedge clock); #1;
    req = 1'b0;
    @(posedge clock); #1;
    check("midop_busy", 32'(busy), 32'd1);
    reset = 1'b0;
    #1;
    exp_rdata = '0;
    check("midop_rst_busy", 32'(busy), 32'd0);
    check("midop_rst_done", 32'(done), 32'd0);
    check("midop_rst_mem_wr", 32'(mem_wr), 32'd0);
    check("midop_rst_rdata", rdata, 32'd0);
    check("midop_rst_mem_addr", mem_addr, 32'd0);
    check("midop_rst_mem_wdata", mem_wdata, 32'd0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b1;
    repeat (6) @(posedge clock);
    #1;
    check("midop_no_write", wr_count - wc0, 0);
    check("midop_no_done", done_count - dc0, 0);
    check("midop_idle", 32'(busy), 32'd0);

    // req held high across a whole sub-word store and a load.
    do_access(1'b1, SZ_BYTE, 1'b0, 32'h45, 32'h000000E7, 1'b1);
    do_access(1'b0, SZ_HALF, 1'b1, 32'h46, 32'h0, 1'b1);

    // Random accesses over the preloaded region.
    for (int i = 0; i < 80; i++) begin
      rsz = 2'($urandom_range(0, 3));
      do_access(1'($urandom), rsz, 1'($urandom), 32'h40 | 32'($urandom_range(0, 63)),
                $urandom, 1'($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
